// File: rtl/rd_ptr_empty_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : rd_ptr_empty_ctrl_if
// Purpose  : Bundles the read-side handshake and status signals that pass
//            between the async-FIFO read controller and its consumer or bench.
// Ports    : none (the interface carries signals only)
//   rd_en / underflow_clr / rq2_wrt_ptr : driven by the master, into the controller
//   rd_ptr, rd_addr, rd_addr_next,
//   rd_accept, empty, almost_empty,
//   rd_level, underflow                 : driven by the controller (slave)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rd_ptr_empty_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W:0]   rq2_wrt_ptr;
  logic              underflow_clr;
  logic [ADDR_W:0]   rd_ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_addr_next;
  logic              rd_accept;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   rd_level;
  logic              underflow;

  modport slave (
    input  rd_en, rq2_wrt_ptr, underflow_clr,
    output rd_ptr, rd_addr, rd_addr_next, rd_accept,
           empty, almost_empty, rd_level, underflow
  );

  modport master (
    output rd_en, rq2_wrt_ptr, underflow_clr,
    input  rd_ptr, rd_addr, rd_addr_next, rd_accept,
           empty, almost_empty, rd_level, underflow
  );
endinterface

`default_nettype wire

// File: rtl/rd_ptr_empty_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rd_ptr_empty_ctrl
// Purpose  : Read-side pointer and flag controller of an async FIFO with
//            DEPTH = 2**ADDR_W words. Keeps binary and Gray read pointers,
//            produces registered empty / almost_empty / fill level and a
//            sticky underflow flag.
// Ports    :
//   rd_clk   in  read clock
//   rd_rst_n in  asynchronous active-low reset
//   bus      slave modport of rd_ptr_empty_ctrl_if:
//     rd_en in, rq2_wrt_ptr in (write Gray ptr already synchronised),
//     underflow_clr in, rd_ptr out (Gray), rd_addr out, rd_addr_next out,
//     rd_accept out (combinational), empty/almost_empty/rd_level out,
//     underflow out (sticky)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_ptr_empty_ctrl #(
  parameter int ADDR_W        = 3,
  parameter int AEMPTY_THRESH = 1
) (
  input  wire                   rd_clk,
  input  wire                   rd_rst_n,
  rd_ptr_empty_ctrl_if.slave    bus
);

  localparam logic [ADDR_W:0] c_AEMPTY_THRESH = (ADDR_W+1)'(AEMPTY_THRESH);

  logic [ADDR_W:0] r_rd_bin;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_rd_level;
  logic            r_empty;
  logic            r_almost_empty;
  logic            r_underflow;

  logic            w_rd_accept;
  logic [ADDR_W:0] w_rd_bin_next;
  logic [ADDR_W:0] w_rd_gray_next;
  logic [ADDR_W:0] w_wq_bin;
  logic [ADDR_W:0] w_level_next;
  logic            w_empty_next;
  logic            w_almost_empty_next;

  // Depends only on rd_en and registered empty, so the RAM read enable
  // never sees the synchronised write pointer combinationally.
  assign w_rd_accept    = bus.rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + (ADDR_W+1)'(w_rd_accept);
  assign w_rd_gray_next = (w_rd_bin_next >> 1) ^ w_rd_bin_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_wq_bin[i] = ^(bus.rq2_wrt_ptr >> i);
    end
  end

  // Modulo subtraction keeps the level correct across pointer wrap; the
  // result is bounded to 0..DEPTH because the writer never laps the reader.
  assign w_level_next        = w_wq_bin - w_rd_bin_next;
  // Full Gray compare including the wrap bit, so full never reads as empty.
  assign w_empty_next        = (w_rd_gray_next == bus.rq2_wrt_ptr);
  assign w_almost_empty_next = (w_level_next <= c_AEMPTY_THRESH);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_rd_bin       <= '0;
      r_rd_ptr       <= '0;
      r_rd_level     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_ptr       <= w_rd_gray_next;
      r_rd_level     <= w_level_next;
      r_empty        <= w_empty_next;
      r_almost_empty <= w_almost_empty_next;
      // A new underflow event takes priority over a clear in the same cycle.
      r_underflow    <= (bus.rd_en & r_empty) | (r_underflow & ~bus.underflow_clr);
    end
  end

  assign bus.rd_ptr       = r_rd_ptr;
  assign bus.rd_addr      = r_rd_bin[ADDR_W-1:0];
  assign bus.rd_addr_next = w_rd_bin_next[ADDR_W-1:0];
  assign bus.rd_accept    = w_rd_accept;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.rd_level     = r_rd_level;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire
